bus_arbiter: RTL and testbench

//  Shares the single system bus (addr_bus/data_bus/rd_bus/wr_bus/data_mask_bus/fc_bus) between
//  NUM_MASTERS requesters (CPU, DMA, loader). Round-robin grant, optional lock for atomic

---
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with lock, watchdog timeout and monitored strobes
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [2:0]             gnt_id,
  output logic                   bus_busy,
  input  logic                   rd_bus,
  input  logic                   wr_bus,
  inout  wire                    fc_bus,
  output logic                   timeout_err,
  output logic [2:0]             err_id
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_TOUT  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       r_gnt_id;
  logic [2:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tout;
  logic [2:0]       r_err_id;
  logic [7:0]       w_req8;
  logic [7:0]       w_lock8;
  logic [3:0]       w_idx;
  logic [2:0]       w_next_id;
  logic             w_start;
  logic             w_active;
  logic             w_fc;
  logic             w_own_req;
  logic             w_own_lock;

  assign w_req8      = 8'(req);
  assign w_lock8     = 8'(lock);
  assign w_start     = rd_bus ^ wr_bus;
  assign w_active    = rd_bus | wr_bus;
  assign w_fc        = (fc_bus == 1'b1);
  assign w_own_req   = w_req8[r_gnt_id];
  assign w_own_lock  = w_lock8[r_gnt_id];
  assign bus_busy    = (r_state != S_IDLE);
  assign gnt         = bus_busy ? NUM_MASTERS'(1) << r_gnt_id : '0;
  assign gnt_id      = r_gnt_id;
  assign timeout_err = r_tout;
  assign err_id      = r_err_id;
  assign fc_bus      = (r_state == S_TOUT) ? 1'b1 : 1'bz;

  // pick the first requester after the last owner; scanning downward lets the nearest one win
  always_comb begin
    w_next_id = '0;
    w_idx     = '0;
    for (int j = NUM_MASTERS; j >= 1; j--) begin
      w_idx = 4'(r_last) + 4'(j);
      w_idx = (w_idx >= 4'(NUM_MASTERS)) ? w_idx - 4'(NUM_MASTERS) : w_idx;
      if (w_req8[w_idx[2:0]]) w_next_id = w_idx[2:0];
    end
  end

  // grant/access/completion state machine with watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt_id <= '0;
      r_last   <= 3'(NUM_MASTERS - 1);
      r_cnt    <= '0;
      r_tout   <= 1'b0;
      r_err_id <= '0;
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        S_IDLE: if (|req) begin
          r_gnt_id <= w_next_id;
          r_state  <= S_GRANT;
        end
        S_GRANT: if (w_start) begin
          r_state <= S_BUSY;
          r_cnt   <= '0;
        end else if (!w_own_req && !w_own_lock) r_state <= S_IDLE;
        S_BUSY: if (w_fc) r_state <= S_DONE;
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          r_state  <= S_TOUT;
          r_tout   <= 1'b1;
          r_err_id <= r_gnt_id;
        end else r_cnt <= r_cnt + CNT_W'(1);
        S_DONE, S_TOUT: if (!w_active) begin
          if (w_own_req && w_own_lock) r_state <= S_GRANT;
          else begin
            r_state <= S_IDLE;
            r_last  <= r_gnt_id;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic         tb_fc = 1'b0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         bus_busy;
  logic         timeout_err;
  logic [2:0]   err_id;
  wire          fc_bus;

  assign fc_bus = tb_fc ? 1'b1 : 1'bz;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .gnt(gnt), .gnt_id(gnt_id),
    .bus_busy(bus_busy), .rd_bus(rd), .wr_bus(wr), .fc_bus(fc_bus),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: owner index, flags for access phases, cycles since access start
  int m_owner, m_last, m_age, m_err;
  bit m_started, m_ending, m_wd, m_pulse;

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_age = 0; m_err = 0;
      m_started = 0; m_ending = 0; m_wd = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && ((req >> c) & 1) != 0) m_owner = c;
      end
    end else if (m_ending) begin
      if (!(rd || wr)) begin
        m_ending = 0;
        m_wd = 0;
        if (!(((req >> m_owner) & 1) != 0 && ((lock >> m_owner) & 1) != 0)) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
    end else if (m_started) begin
      m_age++;
      if (tb_fc) begin
        m_started = 0; m_ending = 1;
      end else if (m_age == TO) begin
        m_started = 0; m_ending = 1; m_wd = 1; m_pulse = 1; m_err = m_owner;
      end
    end else if (rd != wr) begin
      m_started = 1; m_age = 0;
    end else if (((req >> m_owner) & 1) == 0 && ((lock >> m_owner) & 1) == 0) begin
      m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; rd = 0; wr = 0; tb_fc = 0;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_busy", 32'(bus_busy), 0);
    chk("rst_tout", 32'(timeout_err), 0);
    chk("rst_err_id", 32'(err_id), 0);
    chk("rst_fc_z", 32'(fc_bus === 1'b1), 0);
    rst = 1'b0;
  endtask

  task automatic do_access(input bit is_wr, input int lat, input logic [N-1:0] eg);
    rd = !is_wr; wr = is_wr;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("acc_gnt", 32'(gnt), 32'(eg));
    end
    tb_fc = 1;
    tick();
    chk("acc_gnt_fc", 32'(gnt), 32'(eg));
    tb_fc = 0; rd = 0; wr = 0;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic         rd, wr, fc;
    logic [N-1:0] e_gnt;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                              input logic rdv, input logic wrv, input logic fcv, input logic [N-1:0] eg);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.rd = rdv; v.wr = wrv; v.fc = fcv; v.e_gnt = eg;
    vq.push_back(v);
  endfunction

  initial begin
    // single master write, slave completes after two busy cycles
    add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0001, 0, 0, 0, 0, 4'b0001);
    add(0, 4'b0001, 0, 0, 1, 0, 4'b0001);
    add(0, 4'b0001, 0, 0, 1, 0, 4'b0001);
    add(0, 4'b0001, 0, 0, 1, 1, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    // all four requesting: order 0,1,2,3,0 with one idle cycle between owners
    add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
    for (int m = 0; m < N; m++) begin
      add(0, 4'b1111, 0, 0, 0, 0, 4'(1 << m));
      add(0, 4'b1111, 0, 1, 0, 0, 4'(1 << m));
      add(0, 4'b1111, 0, 1, 0, 1, 4'(1 << m));
      add(0, 4'b1111, 0, 0, 0, 0, 4'b0000);
    end
    add(0, 4'b1111, 0, 0, 0, 0, 4'b0001);
    // m0 abandons its grant without an access; pointer still sits after m3
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0110, 0, 0, 0, 0, 4'b0010);
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000);

    foreach (vq[i]) begin
      rst = vq[i].rst; req = vq[i].req; lock = vq[i].lock;
      rd = vq[i].rd; wr = vq[i].wr; tb_fc = vq[i].fc;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vq[i].e_gnt));
      chk($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(vq[i].e_gnt != 0));
      chk($sformatf("vec%0d_tout", i), 32'(timeout_err), 0);
    end
    rst = 0; rd = 0; wr = 0; tb_fc = 0;

    // m2 locks three consecutive accesses, then m3 is next
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    tick();
    chk("lock_first", 32'(gnt), 32'(4'b0100));
    req = 4'b1111;
    for (int a = 0; a < 3; a++) begin
      if (a == 2) lock = 4'b0000;
      do_access(a[0], 2, 4'b0100);
      tick();
      chk("lock_hold", 32'(gnt), (a < 2) ? 32'(4'b0100) : 32'(0));
    end
    tick();
    chk("after_lock", 32'(gnt), 32'(4'b1000));
    req = '0;
    tick();

    // m1 reads unmapped address: watchdog fires 8 cycles after the read starts
    do_reset();
    req = 4'b0010;
    tick();
    chk("to_gnt", 32'(gnt), 32'(4'b0010));
    rd = 1;
    tick();
    for (int c = 1; c < TO; c++) begin
      tick();
      chk("to_fc_wait", 32'(fc_bus === 1'b1), 0);
      chk("to_tout_wait", 32'(timeout_err), 0);
    end
    tick();
    chk("to_fc_on", 32'(fc_bus === 1'b1), 1);
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_err_id", 32'(err_id), 1);
    tick();
    chk("to_pulse_end", 32'(timeout_err), 0);
    chk("to_fc_hold", 32'(fc_bus === 1'b1), 1);
    rd = 0; req = '0;
    tick();
    chk("to_fc_z", 32'(fc_bus === 1'b1), 0);
    chk("to_gnt_off", 32'(gnt), 0);
    chk("to_err_kept", 32'(err_id), 1);

    // reset in the middle of a write drops the grant on the same edge
    do_reset();
    req = 4'b0001;
    tick();
    wr = 1;
    tick();
    tick();
    chk("mid_busy", 32'(gnt), 32'(4'b0001));
    rst = 1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_fc", 32'(fc_bus === 1'b1), 0);
    rst = 0; req = 4'b0110;
    tick();
    chk("mid_regrant", 32'(gnt), 32'(4'b0010));
    wr = 0; req = '0;
    tick();

    // completion arrives on the same edge the watchdog would fire
    do_reset();
    req = 4'b0001;
    tick();
    wr = 1;
    tick();
    for (int c = 1; c < TO; c++) tick();
    tb_fc = 1;
    tick();
    chk("race_tout", 32'(timeout_err), 0);
    chk("race_gnt", 32'(gnt), 32'(4'b0001));
    tb_fc = 0; wr = 0; req = '0;
    tick();
    chk("race_release", 32'(gnt), 0);
    chk("race_err_id", 32'(err_id), 0);
    chk("race_no_pulse", 32'(timeout_err), 0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lock = 4'($urandom) & 4'($urandom);
      rd = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
      tb_fc = ($urandom_range(0, 6) == 0);
      tick();
      chk("rnd_gnt", 32'(gnt), (m_owner < 0) ? 0 : 32'(1 << m_owner));
      chk("rnd_busy", 32'(bus_busy), 32'(m_owner >= 0));
      chk("rnd_onehot", 32'($countones(gnt) <= 1), 1);
      if (m_owner >= 0) chk("rnd_gnt_id", 32'(gnt_id), 32'(m_owner));
      chk("rnd_tout", 32'(timeout_err), 32'(m_pulse));
      chk("rnd_err_id", 32'(err_id), 32'(m_err));
      if (!tb_fc) chk("rnd_fc_drv", 32'(fc_bus === 1'b1), 32'(m_wd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
